// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types for the memory arbiter: FSM states, owner encoding and default widths.
package ysyx_22050612_mem_pkg;

  localparam int AW_DEF = 64;
  localparam int DW_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_22050612_rr_arb2.sv
// Two-way round-robin grant between IFU and LSU; last_grant advances only on an accepted request.
module ysyx_22050612_rr_arb2
  import ysyx_22050612_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_ifu,
  input  logic   req_lsu,
  input  logic   accept,
  output logic   gnt_ifu,
  output logic   gnt_lsu,
  output owner_t gnt_owner
);

  owner_t last_grant;

  // On a tie the requester that did not win last time gets the port
  always_comb begin
    gnt_ifu   = req_ifu & (~req_lsu | (last_grant == OWN_LSU));
    gnt_lsu   = req_lsu & (~req_ifu | (last_grant == OWN_IFU));
    gnt_owner = gnt_lsu ? OWN_LSU : OWN_IFU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWN_LSU;
    end else if (accept) begin
      last_grant <= gnt_owner;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory bridge between IFU and LSU: one transaction in flight,
// round-robin arbitration, responses routed to their owner, watchdog on WAIT.
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic          lsu_resp_valid,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);

  state_t        state, state_n;
  owner_t        owner_q, gnt_owner;
  logic          gnt_ifu, gnt_lsu, accept, tmo_hit;
  logic [CW-1:0] cnt;

  ysyx_22050612_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_ifu   (ifu_req_valid),
    .req_lsu   (lsu_req_valid),
    .accept    (accept),
    .gnt_ifu   (gnt_ifu),
    .gnt_lsu   (gnt_lsu),
    .gnt_owner (gnt_owner)
  );

  // A grant implies the matching valid, so ready alone marks the handshake
  assign ifu_req_ready  = (state == IDLE) & gnt_ifu;
  assign lsu_req_ready  = (state == IDLE) & gnt_lsu;
  assign accept         = ifu_req_ready | lsu_req_ready;
  assign mem_req_valid  = (state == ISSUE);
  assign ifu_resp_valid = (state == RESP) & (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state == RESP) & (owner_q == OWN_LSU);
  assign tmo_hit        = (cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept)                   state_n = ISSUE;
      ISSUE: if (mem_req_ready)            state_n = WAIT;
      WAIT:  if (mem_resp_valid | tmo_hit) state_n = RESP;
      RESP:                                state_n = IDLE;
      default:                             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_IFU;
      mem_addr    <= '0;
      mem_wen     <= 1'b0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      cnt         <= '0;
      ifu_rdata   <= '0;
      lsu_rdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= gnt_owner;
        if (gnt_lsu) begin
          mem_addr  <= lsu_addr;
          mem_wen   <= lsu_wen;
          mem_wdata <= lsu_wdata;
          mem_wmask <= lsu_wmask;
        end else begin
          mem_addr  <= ifu_addr;
          mem_wen   <= 1'b0;
          mem_wdata <= '0;
          mem_wmask <= '0;
        end
      end
      if ((state == ISSUE) && mem_req_ready) begin
        cnt <= '0;
      end else if ((state == WAIT) && (cnt != TMO_MAX)) begin
        cnt <= cnt + CW'(1);
      end
      // A real response in the timeout cycle takes priority over the watchdog
      if (state == WAIT) begin
        if (mem_resp_valid) begin
          if (owner_q == OWN_LSU) lsu_rdata <= mem_rdata;
          else                    ifu_rdata <= mem_rdata;
        end else if (tmo_hit) begin
          if (owner_q == OWN_LSU) lsu_rdata <= '0;
          else                    ifu_rdata <= '0;
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule
